// File: rtl/entrada_teclado_if.sv
// Keypad front-end bus: raw button/switch inputs toward the conditioner and
// the clean digit-strobe outputs toward the lock stage.
interface entrada_teclado_if;
  logic       botao;
  logic [4:1] chaves;
  logic       limpa;
  logic       insere;
  logic [4:1] numero;
  logic [2:0] contagem;
  logic       ocupado;
  logic       erro;

  modport master (
    output botao, chaves, limpa,
    input  insere, numero, contagem, ocupado, erro
  );

  modport slave (
    input  botao, chaves, limpa,
    output insere, numero, contagem, ocupado, erro
  );
endinterface

// File: rtl/entrada_teclado.sv
// Synchronizes, debounces and edge-detects the keypad button, latching the digit
// switches on each confirmed press. Optional BCD rejection: ENTRADA_VALIDA_BCD_EN.
module entrada_teclado #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic               clk,
  input  logic               reset,
  entrada_teclado_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONF_PRESS,
    HELD,
    CONF_RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       botao_m, botao_s;
  logic [4:1] chaves_m, chaves_s;

  logic       insere_q;
  logic [4:1] numero_q;
  logic [2:0] contagem_q;
  logic       ocupado_q;
  logic       erro_q;
  logic       digito_ok;

`ifdef ENTRADA_VALIDA_BCD_EN
  assign digito_ok = (chaves_s <= 4'd9);
`else
  assign digito_ok = 1'b1;
`endif

  // Two-stage synchronizers on the asynchronous button and switches
  always_ff @(posedge clk) begin
    if (!reset) begin
      botao_m  <= 1'b0;
      botao_s  <= 1'b0;
      chaves_m <= 4'b0000;
      chaves_s <= 4'b0000;
    end else begin
      botao_m  <= bus.botao;
      botao_s  <= botao_m;
      chaves_m <= bus.chaves;
      chaves_s <= chaves_m;
    end
  end

  // Debounce FSM; insere/erro default low so they only last one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      insere_q   <= 1'b0;
      numero_q   <= 4'b0000;
      contagem_q <= 3'd0;
      ocupado_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      insere_q <= 1'b0;
      erro_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (botao_s) begin
            state     <= CONF_PRESS;
            cnt       <= '0;
            ocupado_q <= 1'b1;
          end
        end

        CONF_PRESS: begin
          if (!botao_s) begin
            state     <= IDLE;
            cnt       <= '0;
            ocupado_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            if (digito_ok) begin
              insere_q <= 1'b1;
              numero_q <= chaves_s;
              if (contagem_q != 3'd7) contagem_q <= contagem_q + 3'd1;
            end else begin
              erro_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HELD: begin
          if (!botao_s) begin
            state <= CONF_RELEASE;
            cnt   <= '0;
          end
        end

        CONF_RELEASE: begin
          if (botao_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            ocupado_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          ocupado_q <= 1'b0;
        end
      endcase

      // Clear has priority over a coincident accept
      if (bus.limpa) contagem_q <= 3'd0;
    end
  end

  assign bus.insere   = insere_q;
  assign bus.numero   = numero_q;
  assign bus.contagem = contagem_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.erro     = erro_q;

endmodule

// File: tb/tb_entrada_teclado.sv
// Directed plus randomized bench for entrada_teclado against a run-length
// reference model of the debounce behaviour.
module tb_entrada_teclado;

  localparam int unsigned D     = 4;
  localparam int unsigned CNT_W = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  entrada_teclado_if bus ();

  entrada_teclado #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic       m_b1, m_b2;
  logic [3:0] m_c1, m_c2;
  bit         pressed;
  int         hi_run, lo_run;
  logic       m_insere, m_ocupado, m_erro;
  logic [3:0] m_numero;
  logic [2:0] m_contagem;

  // Scenario markers
  int edge_no, pulses, first_pulse, first_ocu, first_erro;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_b1 = 1'b0; m_b2 = 1'b0; m_c1 = 4'd0; m_c2 = 4'd0;
    pressed = 1'b0; hi_run = 0; lo_run = 0;
    m_insere = 1'b0; m_ocupado = 1'b0; m_erro = 1'b0;
    m_numero = 4'd0; m_contagem = 3'd0;
  endtask

  // A press is accepted after D+1 consecutive high synchronized samples while
  // released; a release completes after D+1 consecutive low samples while pressed.
  task automatic model_step();
    bit ok;
    if (!reset) begin
      model_reset();
    end else begin
      m_insere = 1'b0;
      m_erro   = 1'b0;
      if (!pressed) begin
        hi_run = m_b2 ? hi_run + 1 : 0;
        if (hi_run == int'(D) + 1) begin
          pressed = 1'b1;
          hi_run  = 0;
          lo_run  = 0;
`ifdef ENTRADA_VALIDA_BCD_EN
          ok = (m_c2 < 4'd10);
`else
          ok = 1'b1;
`endif
          if (ok) begin
            m_insere = 1'b1;
            m_numero = m_c2;
            if (m_contagem < 3'd7) m_contagem = m_contagem + 3'd1;
          end else begin
            m_erro = 1'b1;
          end
        end
      end else begin
        lo_run = m_b2 ? 0 : lo_run + 1;
        if (lo_run == int'(D) + 1) begin
          pressed = 1'b0;
          lo_run  = 0;
        end
      end
      if (bus.limpa) m_contagem = 3'd0;
      m_ocupado = pressed || (hi_run > 0);
      m_b2 = m_b1; m_b1 = bus.botao;
      m_c2 = m_c1; m_c1 = bus.chaves;
    end
  endtask

  task automatic compare_all();
    check("insere",   8'(bus.insere),   8'(m_insere));
    check("numero",   8'(bus.numero),   8'(m_numero));
    check("contagem", 8'(bus.contagem), 8'(m_contagem));
    check("ocupado",  8'(bus.ocupado),  8'(m_ocupado));
    check("erro",     8'(bus.erro),     8'(m_erro));
  endtask

  task automatic clear_marks();
    edge_no = 0; pulses = 0; first_pulse = 0; first_ocu = 0; first_erro = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    edge_no++;
    if (bus.insere) begin
      pulses++;
      if (first_pulse == 0) first_pulse = edge_no;
    end
    if (bus.ocupado && first_ocu == 0) first_ocu = edge_no;
    if (bus.erro && first_erro == 0) first_erro = edge_no;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hold_left;
    model_reset();
    bus.botao  = 1'b0;
    bus.chaves = 4'd0;
    bus.limpa  = 1'b0;
    clear_marks();

    // Reset values
    reset = 1'b0;
    ticks(2);
    check("rst_insere",   8'(bus.insere),   8'd0);
    check("rst_numero",   8'(bus.numero),   8'd0);
    check("rst_contagem", 8'(bus.contagem), 8'd0);
    check("rst_ocupado",  8'(bus.ocupado),  8'd0);

    // Clean press latency
    reset = 1'b1;
    bus.chaves = 4'd5;
    bus.botao  = 1'b1;
    clear_marks();
    ticks(12);
    check("lat_pulse_edge", 8'(first_pulse), 8'd7);
    check("lat_ocu_edge",   8'(first_ocu),   8'd3);
    check("lat_pulses",     8'(pulses),      8'd1);
    check("lat_numero",     8'(bus.numero),  8'd5);
    check("lat_contagem",   8'(bus.contagem), 8'd1);
    bus.botao = 1'b0;
    ticks(10);

    // Bounce rejected
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    clear_marks();
    bus.botao = 1'b1; tick();
    bus.botao = 1'b1; tick();
    bus.botao = 1'b0; tick();
    bus.botao = 1'b1; tick();
    bus.botao = 1'b0;
    ticks(10);
    check("bounce_pulses",   8'(pulses),       8'd0);
    check("bounce_contagem", 8'(bus.contagem), 8'd0);
    check("bounce_ocupado",  8'(bus.ocupado),  8'd0);

    // Long hold with switches changing after accept
    clear_marks();
    bus.chaves = 4'd5;
    bus.botao  = 1'b1;
    ticks(10);
    bus.chaves = 4'd9;
    ticks(90);
    check("hold_pulses", 8'(pulses),     8'd1);
    check("hold_numero", 8'(bus.numero), 8'd5);
    bus.botao = 1'b0;
    ticks(10);
    clear_marks();
    bus.botao = 1'b1;
    ticks(10);
    check("second_pulses",   8'(pulses),       8'd1);
    check("second_numero",   8'(bus.numero),   8'd9);
    check("second_contagem", 8'(bus.contagem), 8'd2);
    bus.botao = 1'b0;
    ticks(10);

    // Saturation, then clear coinciding with the 9th accept
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    for (int p = 0; p < 8; p++) begin
      bus.chaves = 4'(p);
      bus.botao  = 1'b1;
      ticks(9);
      bus.botao  = 1'b0;
      ticks(10);
    end
    check("sat_contagem", 8'(bus.contagem), 8'd7);
    bus.chaves = 4'd3;
    bus.botao  = 1'b1;
    ticks(6);
    bus.limpa = 1'b1;
    tick();
    bus.limpa = 1'b0;
    check("limpa_insere",   8'(bus.insere),   8'd1);
    check("limpa_contagem", 8'(bus.contagem), 8'd0);
    check("limpa_numero",   8'(bus.numero),   8'd3);
    ticks(3);
    bus.botao = 1'b0;
    ticks(10);

    // Reset in the middle of press confirmation
    bus.chaves = 4'd6;
    bus.botao  = 1'b1;
    ticks(4);
    reset = 1'b0;
    tick();
    check("mid_rst_insere",   8'(bus.insere),   8'd0);
    check("mid_rst_numero",   8'(bus.numero),   8'd0);
    check("mid_rst_contagem", 8'(bus.contagem), 8'd0);
    check("mid_rst_ocupado",  8'(bus.ocupado),  8'd0);
    reset = 1'b1;
    clear_marks();
    ticks(12);
    check("mid_rst_pulse_edge", 8'(first_pulse), 8'd7);
    check("mid_rst_pulses",     8'(pulses),      8'd1);
    bus.botao = 1'b0;
    ticks(10);

    // Non-BCD digit
    bus.chaves = 4'd5;
    bus.botao  = 1'b1;
    ticks(9);
    bus.botao  = 1'b0;
    ticks(10);
    clear_marks();
    bus.chaves = 4'b1100;
    bus.botao  = 1'b1;
    ticks(10);
`ifdef ENTRADA_VALIDA_BCD_EN
    check("bcd_erro_edge", 8'(first_erro), 8'd7);
    check("bcd_pulses",    8'(pulses),     8'd0);
    check("bcd_numero",    8'(bus.numero), 8'd5);
`else
    check("bcd_pulse_edge", 8'(first_pulse), 8'd7);
    check("bcd_erro_edge",  8'(first_erro),  8'd0);
    check("bcd_numero",     8'(bus.numero),  8'b1100);
`endif
    bus.botao = 1'b0;
    ticks(10);

    // Randomized bursty button, switches, clears and occasional resets
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        bus.botao = 1'($urandom_range(0, 1));
        hold_left = int'($urandom_range(1, 12));
      end
      hold_left--;
      bus.chaves = 4'($urandom);
      bus.limpa  = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
